// File: rtl/fft_sequencer_if.sv
// fft_sequencer_if: handshake and RAM-control bundle of the FFT sequencer.
// master = sequencer (drives strobes/addresses), slave = datapath/environment.
//   fft_start/fft_done/busy        : transform control
//   load_valid/load_ready/load_we  : sample load handshake, load_addr bit-reversed
//   bf_rd_en/bf_addr_a/b/tw_idx    : butterfly operand read + twiddle index
//   bf_wr_en/bf_wr_addr_a/b        : butterfly write-back
//   stage                          : current butterfly stage
//   out_valid/out_ready/out_addr   : natural-order unload handshake
interface fft_sequencer_if #(
    parameter int LOG2N = 4
);
    logic             fft_start;
    logic             fft_done;
    logic             busy;
    logic             load_valid;
    logic             load_ready;
    logic             load_we;
    logic [LOG2N-1:0] load_addr;
    logic             bf_rd_en;
    logic [LOG2N-1:0] bf_addr_a;
    logic [LOG2N-1:0] bf_addr_b;
    logic [LOG2N-2:0] tw_idx;
    logic             bf_wr_en;
    logic [LOG2N-1:0] bf_wr_addr_a;
    logic [LOG2N-1:0] bf_wr_addr_b;
    logic [LOG2N-1:0] stage;
    logic             out_valid;
    logic             out_ready;
    logic [LOG2N-1:0] out_addr;

    modport master (
        input  fft_start, load_valid, out_ready,
        output fft_done, busy,
        output load_ready, load_we, load_addr,
        output bf_rd_en, bf_addr_a, bf_addr_b, tw_idx,
        output bf_wr_en, bf_wr_addr_a, bf_wr_addr_b,
        output stage, out_valid, out_addr
    );

    modport slave (
        output fft_start, load_valid, out_ready,
        input  fft_done, busy,
        input  load_ready, load_we, load_addr,
        input  bf_rd_en, bf_addr_a, bf_addr_b, tw_idx,
        input  bf_wr_en, bf_wr_addr_a, bf_wr_addr_b,
        input  stage, out_valid, out_addr
    );
endinterface

// File: rtl/fft_sequencer.sv
// fft_sequencer: control for an in-place radix-2 DIT FFT engine.
// Sequences bit-reversed load, LOG2N butterfly stages with a BF_LAT-cycle
// drain barrier each, then natural-order unload and a one-cycle done pulse.
// Ports: clk, rst (async, active high), bus (fft_sequencer_if.master).
module fft_sequencer #(
    parameter int N_POINTS = 16,
    parameter int LOG2N    = 4,
    parameter int BF_LAT   = 3
) (
    input  logic            clk,
    input  logic            rst,
    fft_sequencer_if.master bus
);
    localparam int JW = LOG2N - 1;
    localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

    localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N_POINTS - 1);
    localparam logic [LOG2N-1:0] S_LAST   = LOG2N'(LOG2N - 1);
    localparam logic [LOG2N-1:0] ONE      = LOG2N'(1);
    localparam logic [JW-1:0]    J_LAST   = JW'(N_POINTS / 2 - 1);
    localparam logic [JW-1:0]    J_ONE    = JW'(1);
    localparam logic [DW-1:0]    D_LAST   = DW'(BF_LAT - 1);
    localparam logic [DW-1:0]    D_ONE    = DW'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_COMP   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_UNLOAD = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]       state;
    logic [LOG2N-1:0] cnt;
    logic [LOG2N-1:0] s;
    logic [JW-1:0]    j;
    logic [DW-1:0]    dcnt;

    logic rd_en;
    logic ld_acc;
    logic out_acc;

    assign rd_en   = (state == S_COMP);
    assign ld_acc  = (state == S_LOAD) && bus.load_valid;
    assign out_acc = (state == S_UNLOAD) && bus.out_ready;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    // Butterfly addressing, all LOG2N bits wide so results wrap mod N.
    logic [LOG2N-1:0] jx;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] grp;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [JW-1:0]    tw;

    always_comb begin
        jx     = {1'b0, j};
        span   = ONE << s;
        pos    = jx & (span - ONE);
        grp    = jx >> s;
        addr_a = (grp << (s + ONE)) | pos;
        addr_b = addr_a + span;
        // pos < 2^s <= N/2, so it always fits the twiddle width
        tw     = pos[JW-1:0] << (S_LAST - s);
    end

    logic [LOG2N-1:0] rd_a;
    logic [LOG2N-1:0] rd_b;

    assign rd_a = rd_en ? addr_a : '0;
    assign rd_b = rd_en ? addr_b : '0;

    // Write-back delay line; cleared by reset so no stale write survives.
    logic [BF_LAT-1:0] wp_en;
    logic [LOG2N-1:0]  wp_a [BF_LAT];
    logic [LOG2N-1:0]  wp_b [BF_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_en <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
                wp_a[i] <= '0;
                wp_b[i] <= '0;
            end
        end else begin
            wp_en[0] <= rd_en;
            wp_a[0]  <= rd_a;
            wp_b[0]  <= rd_b;
            for (int i = 1; i < BF_LAT; i++) begin
                wp_en[i] <= wp_en[i-1];
                wp_a[i]  <= wp_a[i-1];
                wp_b[i]  <= wp_b[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            s     <= '0;
            j     <= '0;
            dcnt  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.fft_start) begin
                        state <= S_LOAD;
                        cnt   <= '0;
                    end
                end
                S_LOAD: begin
                    if (ld_acc) begin
                        if (cnt == CNT_LAST) begin
                            state <= S_COMP;
                            cnt   <= '0;
                            s     <= '0;
                            j     <= '0;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                end
                S_COMP: begin
                    if (j == J_LAST) begin
                        state <= S_DRAIN;
                        j     <= '0;
                        dcnt  <= '0;
                    end else begin
                        j <= j + J_ONE;
                    end
                end
                // Stage barrier: last write of stage s lands before
                // the first read of stage s+1.
                S_DRAIN: begin
                    if (dcnt == D_LAST) begin
                        if (s == S_LAST) begin
                            state <= S_UNLOAD;
                            s     <= '0;
                            cnt   <= '0;
                        end else begin
                            state <= S_COMP;
                            s     <= s + ONE;
                            j     <= '0;
                        end
                    end else begin
                        dcnt <= dcnt + D_ONE;
                    end
                end
                S_UNLOAD: begin
                    if (out_acc) begin
                        if (cnt == CNT_LAST) begin
                            state <= S_DONE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = (state != S_IDLE);
    assign bus.fft_done   = (state == S_DONE);
    assign bus.load_ready = (state == S_LOAD);
    assign bus.load_we    = ld_acc;
    assign bus.load_addr  = (state == S_LOAD) ? bitrev(cnt) : '0;

    assign bus.bf_rd_en  = rd_en;
    assign bus.bf_addr_a = rd_a;
    assign bus.bf_addr_b = rd_b;
    assign bus.tw_idx    = rd_en ? tw : '0;

    assign bus.bf_wr_en     = wp_en[BF_LAT-1];
    assign bus.bf_wr_addr_a = wp_a[BF_LAT-1];
    assign bus.bf_wr_addr_b = wp_b[BF_LAT-1];

    assign bus.stage = (state == S_COMP || state == S_DRAIN) ? s : '0;

    assign bus.out_valid = (state == S_UNLOAD);
    assign bus.out_addr  = (state == S_UNLOAD) ? cnt : '0;
endmodule

// File: tb/tb_fft_sequencer.sv
// tb_fft_sequencer: directed bench for fft_sequencer (N=16, BF_LAT=3).
// A scoreboard of expected reads, writes, load and unload addresses.
module tb_fft_sequencer;
    localparam int N   = 16;
    localparam int LG  = 4;
    localparam int LAT = 3;

    logic tb_clk = 1'b0;
    logic rst;

    always #5 tb_clk = ~tb_clk;

    fft_sequencer_if #(.LOG2N(LG)) bus ();

    fft_sequencer #(
        .N_POINTS(N),
        .LOG2N(LG),
        .BF_LAT(LAT)
    ) dut (
        .clk(tb_clk),
        .rst(rst),
        .bus(bus.master)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge tb_clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] tw;
        logic [3:0] st;
    } rd_t;

    typedef struct {
        int         due;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] st;
    } wr_t;

    rd_t        exp_rd [$];
    wr_t        wrq    [$];
    logic [3:0] ldq    [$];
    logic [3:0] outq   [$];

    logic [3:0] BR [16] = '{0, 8, 4, 12, 2, 10, 6, 14,
                            1, 9, 5, 13, 3, 11, 7, 15};

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_out();
        return {26'd0,
                bus.busy, bus.fft_done, bus.load_ready, bus.load_we,
                bus.load_addr, bus.bf_rd_en, bus.bf_addr_a, bus.bf_addr_b,
                bus.tw_idx, bus.bf_wr_en, bus.bf_wr_addr_a,
                bus.bf_wr_addr_b, bus.stage, bus.out_valid, bus.out_addr};
    endfunction

    function automatic void flush_model();
        exp_rd.delete();
        wrq.delete();
        ldq.delete();
        outq.delete();
    endfunction

    // Butterfly order built per stage as groups of 2*span, then position.
    function automatic void fill_model();
        flush_model();
        for (int st = 0; st < LG; st++) begin
            int span;
            span = 1 << st;
            for (int g = 0; g < N / (2 * span); g++) begin
                for (int p = 0; p < span; p++) begin
                    rd_t ne;
                    ne.a  = 4'(g * 2 * span + p);
                    ne.b  = 4'(g * 2 * span + p + span);
                    ne.tw = 3'(p * (N / (2 * span)));
                    ne.st = 4'(st);
                    exp_rd.push_back(ne);
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            ldq.push_back(BR[k]);
            outq.push_back(4'(k));
        end
    endfunction

    rd_t        e;
    wr_t        w;
    wr_t        nw;
    bit         have_e;
    bit         have_w;
    bit         have_l;
    bit         have_o;
    int         stale;
    logic [3:0] lq;
    logic [3:0] oq;

    always @(negedge tb_clk) begin
        if (!rst) begin
            have_e = 1'b0;
            if (bus.bf_rd_en) begin
                stale = 0;
                foreach (wrq[i]) if (wrq[i].st != bus.stage) stale++;
                check("rd_before_prev_wr", stale, 0);
                have_e = (exp_rd.size() != 0);
                check("rd_expected", have_e, 1'b1);
                if (have_e) begin
                    e = exp_rd.pop_front();
                    check("rd_addr_tw_stage",
                          {bus.bf_addr_a, bus.bf_addr_b,
                           bus.tw_idx, bus.stage},
                          {e.a, e.b, e.tw, e.st});
                end
            end
            if (bus.bf_wr_en) begin
                have_w = (wrq.size() != 0);
                check("wr_expected", have_w, 1'b1);
                if (have_w) begin
                    w = wrq.pop_front();
                    check("wr_addr",
                          {bus.bf_wr_addr_a, bus.bf_wr_addr_b},
                          {w.a, w.b});
                    check("wr_latency", cyc, w.due);
                end
            end
            if (have_e) begin
                nw.due = cyc + LAT;
                nw.a   = e.a;
                nw.b   = e.b;
                nw.st  = e.st;
                wrq.push_back(nw);
            end
            if (bus.load_we) begin
                have_l = (ldq.size() != 0);
                check("load_expected", have_l, 1'b1);
                if (have_l) begin
                    lq = ldq.pop_front();
                    check("load_addr", bus.load_addr, lq);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                have_o = (outq.size() != 0);
                check("out_expected", have_o, 1'b1);
                if (have_o) begin
                    oq = outq.pop_front();
                    check("out_addr", bus.out_addr, oq);
                end
            end
        end
    end

    task automatic xfer(input bit stall, input bit bp, input bit kill);
        int bc;
        int ldc;
        int cpc;
        int ulc;
        int stall_left;
        int bp_left;
        int post;
        bit fin;
        bit stall_used;
        bit bp_used;
        bit killed;
        bc = 0; ldc = 0; cpc = 0; ulc = 0;
        stall_left = 0; bp_left = 0; post = 0;
        fin = 0; stall_used = 0; bp_used = 0; killed = 0;
        fill_model();
        @(posedge tb_clk);
        #1;
        bus.fft_start  = 1'b1;
        bus.load_valid = 1'b1;
        bus.out_ready  = 1'b1;
        for (int k = 0; k < 400 && !fin; k++) begin
            @(posedge tb_clk);
            #1;
            bus.fft_start = 1'b0;
            if (killed) begin
                rst            = 1'b0;
                bus.load_valid = 1'b0;
                bus.out_ready  = 1'b0;
            end else begin
                if (stall && !stall_used && bus.load_ready &&
                    bus.load_addr == 4'd2) begin
                    stall_left = 5;
                    stall_used = 1'b1;
                end
                bus.load_valid = (stall_left == 0);
                if (bp && !bp_used && bus.out_valid &&
                    bus.out_addr == 4'd6) begin
                    bp_left       = 4;
                    bp_used       = 1'b1;
                    bus.fft_start = 1'b1;
                end
                bus.out_ready = (bp_left == 0);
                if (kill && bus.stage == 4'd2 && bus.bf_rd_en &&
                    bus.bf_addr_a == 4'd8) begin
                    rst = 1'b1;
                    #1;
                    check("rst_outputs_zero", all_out(), 64'd0);
                    flush_model();
                    killed = 1'b1;
                end
            end
            @(negedge tb_clk);
            if (k == 0) check("busy_rise", bus.busy, 1'b1);
            if (killed) begin
                check("post_rst_idle", {bus.busy, bus.bf_wr_en}, 2'b00);
                post++;
                fin = (post == 10);
            end else begin
                if (bus.busy) bc++;
                if (bus.load_ready) ldc++;
                else if (bus.out_valid) ulc++;
                else if (bus.busy && !bus.fft_done) cpc++;
                if (stall_left > 0) begin
                    check("load_stall_hold",
                          {bus.load_addr, bus.load_we}, {4'd2, 1'b0});
                    stall_left--;
                end
                if (bp_left > 0) begin
                    check("unload_bp_hold",
                          {bus.out_addr, bus.out_valid}, {4'd6, 1'b1});
                    bp_left--;
                end
                if (bus.fft_done) begin
                    fin = 1'b1;
                    check("busy_in_done", bus.busy, 1'b1);
                    check("done_cycle", bc,
                          77 + (stall ? 5 : 0) + (bp ? 4 : 0));
                    check("load_cycles", ldc, 16 + (stall ? 5 : 0));
                    check("compute_cycles", cpc, 44);
                    check("unload_cycles", ulc, 16 + (bp ? 4 : 0));
                end
            end
        end
        check("xfer_finished", fin, 1'b1);
        if (!killed) begin
            @(posedge tb_clk);
            #1;
            @(negedge tb_clk);
            check("done_one_cycle", {bus.fft_done, bus.busy}, 2'b00);
            check("scoreboard_empty",
                  exp_rd.size() + wrq.size() + ldq.size() + outq.size(), 0);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.fft_start  = 1'b0;
        bus.load_valid = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (3) @(negedge tb_clk);
        check("reset_outputs", all_out(), 64'd0);
        @(posedge tb_clk);
        #1;
        rst = 1'b0;
        @(negedge tb_clk);
        check("idle_after_reset", all_out(), 64'd0);

        xfer(1'b0, 1'b0, 1'b0);
        xfer(1'b1, 1'b1, 1'b0);
        xfer(1'b0, 1'b0, 1'b1);
        xfer(1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fft_sequencer.md
Name: fft_sequencer

Overview:
- Control block for the in-place radix-2 DIT FFT engine; owns the sample RAM address and enable lines and the butterfly pipeline write-back.
- Sequences four phases per transform: bit-reversed load, LOG2N butterfly stages, drain barriers, natural-order unload.
- Started by a `fft_start` pulse from the setup/top level. Reports completion with a one-cycle `fft_done` pulse.

Parameters:
- N_POINTS, 16: transform size, power of two, 4..1024.
- LOG2N, 4: log2(N_POINTS).
- BF_LAT, 3: butterfly pipeline latency in cycles, from read to write-back, ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fft_start  in  1  start request; sampled in IDLE only.
- fft_done  out  1  one-cycle pulse when the transform is complete.
- busy  out  1  high in every state except IDLE.
- load_valid  in  1  input sample present.
- load_ready  out  1  high in LOAD.
- load_we  out  1  = load_valid & load_ready.
- load_addr  out  LOG2N  bit-reversed sample count.
- bf_rd_en  out  1  butterfly operand read.
- bf_addr_a / bf_addr_b  out  LOG2N each  operand read addresses.
- tw_idx  out  LOG2N-1  twiddle ROM index.
- bf_wr_en  out  1  result write-back.
- bf_wr_addr_a / bf_wr_addr_b  out  LOG2N each  write addresses.
- stage  out  LOG2N  current stage number.
- out_valid  out  1  high in UNLOAD.
- out_ready  in  1  downstream accept.
- out_addr  out  LOG2N  natural-order read address.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0; write-delay pipeline cleared.
- IDLE:
  - `fft_start` = 1 moves to LOAD on the next edge.
  - `fft_start` is ignored in every other state.
- LOAD:
  - `load_ready` = 1.
  - `load_addr` = bitrev(cnt).
  - Each `load_valid` & `load_ready` increments cnt.
  - The accept with cnt = N-1 moves to COMPUTE with stage = 0 and j = 0.
  - A stalled `load_valid` holds the state.
- COMPUTE, one butterfly per cycle, stage s, index j from 0 to N/2-1:
  - `bf_rd_en` = 1.
  - span = 1<<s, grp = j>>s, pos = j & (span-1).
  - `bf_addr_a` = (grp<<(s+1)) | pos; `bf_addr_b` = `bf_addr_a` + span.
  - `tw_idx` = pos << (LOG2N-1-s).
  - After j = N/2-1, move to DRAIN.
- Write-back:
  - `bf_wr_en`, `bf_wr_addr_a` and `bf_wr_addr_b` are `bf_rd_en`, `bf_addr_a` and `bf_addr_b` delayed by exactly BF_LAT cycles through a shift pipeline.
- DRAIN:
  - Lasts BF_LAT cycles with `bf_rd_en` = 0. This is the stage barrier that prevents read-after-write hazards.
  - At the end: if s = LOG2N-1, move to UNLOAD; otherwise s increments, j resets and the state returns to COMPUTE.
  - `bf_wr_en` is never high outside COMPUTE and DRAIN.
- UNLOAD:
  - `out_valid` = 1, `out_addr` = cnt.
  - cnt advances only on `out_valid` & `out_ready`; `out_addr` holds while `out_ready` = 0.
  - The accept at cnt = N-1 moves to DONE.
- DONE: `fft_done` = 1 for exactly one cycle, then IDLE. `busy` is still 1 in DONE.
- Cycle count with `load_valid` and `out_ready` held high:
  - LOAD: N cycles.
  - Compute: LOG2N·(N/2 + BF_LAT) cycles.
  - UNLOAD: N cycles.
  - DONE: 1 cycle.
- `rst` mid-operation: immediate return to IDLE; all outputs 0; the pending write pipeline is discarded, so no late `bf_wr_en` occurs.
- `stage` is valid in COMPUTE and DRAIN, and 0 elsewhere.
- All address arithmetic is modulo 2^LOG2N; there are no wider intermediates on the outputs.

Test Plan:
- Reset, then `fft_start` pulse with continuous `load_valid` and `out_ready` (N=16, BF_LAT=3):
  - `busy` rises 1 cycle after start.
  - LOAD 16 cycles, compute 44 cycles, UNLOAD 16 cycles.
  - `fft_done` pulses on cycle 77 after the start edge, for 1 cycle.
- LOAD bit-reversal: counts 0,1,2,3,15 → `load_addr` 0,8,4,12,15. Drop `load_valid` for 5 cycles mid-load → `load_addr` holds and no `load_we`.
- Address generation, checked against the formulas:
  - stage 0, j=7 → a=14, b=15, tw=0.
  - stage 1, j=3 → a=5, b=7, tw=4.
  - stage 3, j=5 → a=5, b=13, tw=5.
- Write-back timing:
  - each `bf_wr_en` and its address pair appears exactly 3 cycles after the matching read.
  - no read of stage s+1 occurs before the last write of stage s.
- UNLOAD backpressure: `out_ready` low at `out_addr` = 6 for 4 cycles → `out_addr` stays 6 and `out_valid` stays 1; it resumes at 7. A `fft_start` pulse during UNLOAD is ignored.
- Assert `rst` during stage 2 of COMPUTE:
  - all outputs are 0 the same cycle.
  - no `bf_wr_en` follows.
  - a subsequent `fft_start` runs a full, correct transform.
